// File: rtl/burst_pop_scheduler.sv
// burst_pop_scheduler
// Round-robin burst scheduler that drains QUEUE_QUANTITY input FIFOs into one
// shared downstream FIFO. Each grant pops up to BURST_MAX words. Downstream
// almost-full pauses the burst without giving up the grant. The push and
// out_selector outputs are pop and selector delayed by one clock, which lines
// them up with the one-cycle read latency of the input FIFOs.

module burst_pop_scheduler #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int SEL_BITS       = 2,
   parameter int BURST_MAX      = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enb,
   input  logic [QUEUE_QUANTITY-1:0] buf_empty,
   input  logic                      dst_almost_full,
   output logic [QUEUE_QUANTITY-1:0] pop,
   output logic [SEL_BITS-1:0]       selector,
   output logic                      push,
   output logic [SEL_BITS-1:0]       out_selector,
   output logic                      busy
);

   // The burst counter must hold BURST_MAX-1 and is never narrower than SEL_BITS+1.
   localparam int CNT_MIN  = SEL_BITS + 1;
   localparam int CNT_NEED = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam int CNT_W    = (CNT_NEED > CNT_MIN) ? CNT_NEED : CNT_MIN;

   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BURST_MAX - 1);
   localparam logic [SEL_BITS-1:0] SEL_LAST = SEL_BITS'(QUEUE_QUANTITY - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [SEL_BITS-1:0] selector_next;
   logic [SEL_BITS-1:0] last_grant;
   logic [SEL_BITS-1:0] last_grant_next;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    count_next;

   logic [SEL_BITS-1:0] search_pick;
   logic [SEL_BITS-1:0] search_cand;
   logic                search_found;
   logic                cur_empty;
   logic                pop_ok;

   // Round-robin search. Start one past the last granted queue, wrap from
   // N-1 to 0, and pick the first queue that is not empty.
   always_comb begin
      search_found = 1'b0;
      search_pick  = selector;
      search_cand  = '0;
      for (int i = 1; i <= QUEUE_QUANTITY; i++) begin
         search_cand = SEL_BITS'((int'(last_grant) + i) % QUEUE_QUANTITY);
         if (!search_found && !buf_empty[search_cand]) begin
            search_found = 1'b1;
            search_pick  = search_cand;
         end
      end
   end

   // Pop strobe. It is combinational so the FIFO read happens in the same
   // cycle as the flags that allowed it.
   always_comb begin
      cur_empty = buf_empty[selector];
      pop_ok    = (state == BURST) && enb && !cur_empty && !dst_almost_full;
      pop       = '0;
      if (pop_ok) begin
         pop[selector] = 1'b1;
      end
      busy = (state == BURST);
   end

   // Next-state logic. In BURST, abort beats drain, drain beats pause, and
   // pause beats the normal pop/count handling.
   always_comb begin
      state_next      = state;
      selector_next   = selector;
      last_grant_next = last_grant;
      count_next      = count;
      case (state)
         IDLE: begin
            if (enb && search_found && !dst_almost_full) begin
               selector_next = search_pick;
               count_next    = '0;
               state_next    = BURST;
            end
         end
         BURST: begin
            if (!enb) begin
               state_next      = IDLE;
               last_grant_next = selector;
               count_next      = '0;
            end else if (cur_empty) begin
               state_next      = IDLE;
               last_grant_next = selector;
               count_next      = '0;
            end else if (dst_almost_full) begin
               state_next = BURST;
            end else if (count == CNT_LAST) begin
               state_next      = IDLE;
               last_grant_next = selector;
               count_next      = '0;
            end else begin
               count_next = count + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State register. Reset parks last_grant on the top queue so that the
   // first grant after reset goes to queue 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         selector   <= '0;
         last_grant <= SEL_LAST;
         count      <= '0;
      end else begin
         state      <= state_next;
         selector   <= selector_next;
         last_grant <= last_grant_next;
         count      <= count_next;
      end
   end

   // Delay pop and selector by one clock so they arrive with the FIFO read data.
   always_ff @(posedge clk) begin
      if (!rst) begin
         push         <= 1'b0;
         out_selector <= '0;
      end else begin
         push <= |pop;
         if (|pop) begin
            out_selector <= selector;
         end
      end
   end

endmodule
